// File: rtl/c1_checksum_acc.sv
// One's-complement checksum accumulator.
// Words arrive over a valid/ready handshake and are folded into a running
// sum with end-around carry. After the last word, the raw sum and its
// complement are held for a downstream consumer until it accepts them.
module c1_checksum_acc #(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 15,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] data_in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] checksum,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t           state_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  // One's-complement add: a carry out of the top bit wraps back into bit 0.
  // The result is not normalised, so negative zero (all ones) can appear.
  function automatic logic [WIDTH-1:0] oc_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[WIDTH-1:0] + WIDTH'(t[WIDTH]);
  endfunction

  assign sum_d = oc_add(sum_q, data_in);

  // Packet FSM together with the accumulator, counter and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sum_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            // Once the packet is full, extra words are dropped. The error
            // flag is raised instead of letting the counter wrap.
            if (count_q == MAX_CNT) begin
              err_q <= 1'b1;
            end else begin
              sum_q   <= sum_d;
              count_q <= count_q + CNT_W'(1);
            end
            if (in_last) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The handshake flags are decoded directly from the state register, so
  // they change only on a clock edge.
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign checksum  = ~sum_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_c1_checksum_acc.sv
// Testbench for c1_checksum_acc. The stimulus pushes hand-computed results
// into a queue, and a monitor pops and compares them on each out handshake.
module tb_c1_checksum_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_last;
  logic [3:0] data_in;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] sum;
  logic [3:0] checksum;
  logic [3:0] count;
  logic       err;
  logic       busy;

  typedef struct packed {
    logic [3:0] sum;
    logic [3:0] ck;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  c1_checksum_acc #(.WIDTH(4), .MAX_WORDS(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .checksum  (checksum),
    .count     (count),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    data_in  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] c, input logic e);
    exp_t x;
    x.sum = s;
    x.ck  = ~s;
    x.cnt = c;
    x.err = e;
    exp_q.push_back(x);
  endtask

  // Complete the out handshake and confirm the return to IDLE.
  task automatic drain(input string name);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual sum=%0h required none", sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_sum", 32'(sum), 32'(e.sum));
        chk("mon_checksum", 32'(checksum), 32'(e.ck));
        chk("mon_count", 32'(count), 32'(e.cnt));
        chk("mon_err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    data_in = 4'h0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_checksum", 32'(checksum), 32'hF);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // A word offered in IDLE is ignored.
    in_valid = 1'b1; data_in = 4'h7; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("idle_ignore_count", 32'(count), 32'h0);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // Reset in the middle of ACC aborts the packet.
    start_pkt();
    chk("acc_in_ready", 32'(in_ready), 32'd1);
    send(4'h3, 1'b0);
    send(4'h5, 1'b0);
    chk("acc_sum_3p5", 32'(sum), 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_sum", 32'(sum), 32'h0);
    chk("abort_count", 32'(count), 32'h0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_checksum", 32'(checksum), 32'hF);
    chk("abort_busy", 32'(busy), 32'd0);

    // 0011 + 0101 = 1000
    start_pkt();
    send(4'h3, 1'b0);
    push(4'h8, 4'd2, 1'b0);
    send(4'h5, 1'b1);
    drain("pkt_basic");

    // 1111 + 0001 = 1_0000, and the end-around carry gives 0001.
    start_pkt();
    send(4'hF, 1'b0);
    push(4'h1, 4'd2, 1'b0);
    send(4'h1, 1'b1);
    drain("pkt_carry");

    // Single-word packet: 0 + 0 stays 0.
    start_pkt();
    push(4'h0, 4'd1, 1'b0);
    send(4'h0, 1'b1);
    drain("pkt_single");

    // 1001+1000 -> 0010, then 0010+0110 -> 1000. Five cycles of backpressure
    // follow, with start asserted during the handshake.
    start_pkt();
    send(4'h9, 1'b0);
    send(4'h8, 1'b0);
    push(4'h8, 4'd3, 1'b0);
    send(4'h6, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; data_in = 4'h1; in_last = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h8);
      chk("bp_checksum", 32'(checksum), 32'h7);
      chk("bp_count", 32'(count), 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    start = 1'b1;
    drain("pkt_bp");
    start = 1'b0;
    chk("start_not_queued_in_ready", 32'(in_ready), 32'd0);

    // Overflow: the 16th word is dropped and err is set.
    start_pkt();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push(4'hF, 4'd15, 1'b1);
      send(4'h1, (i == 15));
    end
    chk("ovf_checksum_direct", 32'(checksum), 32'h0);
    drain("pkt_ovf");

    tick(); tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
